axi4_slave_ram: RTL and testbench
=================================

# axi4_slave_ram
AXI4 full-protocol responder backed by an internal word-addressed RAM. It is the target endpoint for the team's `axi4_master` on interconnect and bench links. It supports FIXED and INCR bursts of up to 256 beats, with independent write and read engines that run concurrently.
## Interface
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, data width (32 or 64); BPB = DATA_WIDTH/8 bytes per beat
- ID_WIDTH, 4, transaction ID width
- MEM_DEPTH, 1024, RAM depth in words
- aclk  in  1  clock, all logic on rising edge
- aresetn  in  1  asynchronous active-low reset
- s_axi_awid/awaddr/awlen/awsize/awburst  in  ID_WIDTH/ADDR_WIDTH/8/3/2  write address fields
- s_axi_awvalid  in  1  AW valid
- s_axi_awready  out  1  AW ready
- s_axi_wdata/wstrb/wlast  in  DATA_WIDTH/BPB/1  write data, byte strobes, last beat
- s_axi_wvalid  in  1  W valid
- s_axi_wready  out  1  W ready
- s_axi_bid/bresp  out  ID_WIDTH/2  write response ID and code
- s_axi_bvalid  out  1  B valid
- s_axi_bready  in  1  B ready
- s_axi_arid/araddr/arlen/arsize/arburst  in  ID_WIDTH/ADDR_WIDTH/8/3/2  read address fields
- s_axi_arvalid  in  1  AR valid
- s_axi_arready  out  1  AR ready
- s_axi_rid/rdata/rresp/rlast  out  ID_WIDTH/DATA_WIDTH/2/1  read ID, data, response, last
- s_axi_rvalid  out  1  R valid
- s_axi_rready  in  1  R ready
## Operation
- Word index: addr >> log2(BPB). Low address bits are ignored, so unaligned starts are aligned down.
- Next beat address: INCR adds BPB; FIXED holds the address.
- Burst-level errors:
  - Burst 2'b10 (WRAP) or 2'b11, or size != log2(BPB), gives SLVERR for the whole burst.
  - No RAM writes occur; read data is 0.
- Per-beat errors: a word index >= MEM_DEPTH gives DECERR for that beat. Writes are suppressed and rdata is 0.
- Write FSM:
  - W_IDLE (awready=1): on AW handshake, latch id/addr/len/burst/err and go to W_DATA.
  - W_DATA (wready=1): each beat writes the bytes enabled by wstrb. The burst ends on the beat with wlast=1, then go to W_RESP.
  - Beat-count checks: beat count != awlen+1 gives SLVERR. Beats after the awlen+1 count are not written.
  - W_RESP (bvalid=1): on bready, go to W_IDLE.
- bresp priority: SLVERR > DECERR > OKAY. bresp is DECERR if any beat hit DECERR.
- Read FSM:
  - R_IDLE (arready=1): on AR handshake, latch fields and go to R_FETCH.
  - R_FETCH: perform the synchronous RAM read, then go to R_DATA.
  - R_DATA (rvalid=1): rlast=1 on beat arlen. On rready with more beats remaining, advance the address and go to R_FETCH. On rready with the last beat, go to R_IDLE.
- The RAM has one write port and one read port. A read and write to the same word in the same cycle returns the old data.
## Timing
- Reset values: awready=1, arready=1, wready=0, bvalid=0, rvalid=0, rlast=0. bid, rid, bresp, rresp and rdata are 0. RAM contents are not reset.
- Handshake rules: outputs are held stable while valid=1 and ready=0. A handshake occurs on any edge where valid and ready are both high.
- Write latency: wready rises 1 cycle after the AW handshake. bvalid rises 1 cycle after the wlast handshake. A new AW is accepted 1 cycle after the B handshake.
- Read latency: the first rvalid is 2 cycles after the AR handshake. Throughput is 1 beat per 2 cycles. arready rises 1 cycle after the last R handshake.
- The read and write engines are fully independent and may be active in the same cycle.
- W beats arriving before AW are not accepted (wready=0 in W_IDLE).
- aresetn low mid-burst forces both FSMs to IDLE immediately. The partial burst is abandoned and no response is generated.
## Test plan
- INCR write: awaddr=0x10, awlen=3, wdata 0xA0..0xA3, wstrb=0xF -> bresp=OKAY, bid=awid. Then INCR read of 0x10 with len 3 -> 0xA0..0xA3, rlast on beat 3 only, rresp=OKAY.
- Byte strobes on a 32-bit word: write 0x11223344 with wstrb=0xF, then 0xAABBCCDD with wstrb=0x5 -> read returns 0x11BB33DD.
- FIXED write, awlen=2 to 0x40, data 1,2,3 -> read returns 3. Burst=2'b11 -> bresp=SLVERR and the RAM is unchanged.
- Address and beat-count errors:
  - Address 4*MEM_DEPTH -> bresp=DECERR; read gives rdata=0, rresp=DECERR.
  - Early wlast on beat 1 of awlen=3 -> bresp=SLVERR.
- Backpressure and concurrency:
  - Hold rready=0 for 5 cycles mid-burst -> rdata/rlast stay stable.
  - Hold bready=0 -> bvalid is held.
  - Concurrent read and write bursts both complete correctly.
- Reset mid-burst: assert aresetn=0 during beat 2 of a write -> all outputs take their reset values. A subsequent full burst completes with OKAY.

Source files
------------

// File: rtl/axi4_slave_ram_if.sv
// AXI4 bus bundle shared by axi4_slave_ram and its masters.
// Contents: the AW, W, B, AR and R channels, with signals named s_axi_*.
// Modports:
//   slave  - the responder side (the RAM)
//   master - the requester side
interface axi4_slave_ram_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
);
  localparam int BPB = DATA_WIDTH / 8;

  logic [ID_WIDTH-1:0]   s_axi_awid;
  logic [ADDR_WIDTH-1:0] s_axi_awaddr;
  logic [7:0]            s_axi_awlen;
  logic [2:0]            s_axi_awsize;
  logic [1:0]            s_axi_awburst;
  logic                  s_axi_awvalid, s_axi_awready;
  logic [DATA_WIDTH-1:0] s_axi_wdata;
  logic [BPB-1:0]        s_axi_wstrb;
  logic                  s_axi_wlast, s_axi_wvalid, s_axi_wready;
  logic [ID_WIDTH-1:0]   s_axi_bid;
  logic [1:0]            s_axi_bresp;
  logic                  s_axi_bvalid, s_axi_bready;
  logic [ID_WIDTH-1:0]   s_axi_arid;
  logic [ADDR_WIDTH-1:0] s_axi_araddr;
  logic [7:0]            s_axi_arlen;
  logic [2:0]            s_axi_arsize;
  logic [1:0]            s_axi_arburst;
  logic                  s_axi_arvalid, s_axi_arready;
  logic [ID_WIDTH-1:0]   s_axi_rid;
  logic [DATA_WIDTH-1:0] s_axi_rdata;
  logic [1:0]            s_axi_rresp;
  logic                  s_axi_rlast, s_axi_rvalid, s_axi_rready;

  modport slave (
    input  s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awvalid,
    output s_axi_awready,
    input  s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
    output s_axi_wready,
    output s_axi_bid, s_axi_bresp, s_axi_bvalid,
    input  s_axi_bready,
    input  s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arvalid,
    output s_axi_arready,
    output s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
    input  s_axi_rready
  );

  modport master (
    output s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awvalid,
    input  s_axi_awready,
    output s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
    input  s_axi_wready,
    input  s_axi_bid, s_axi_bresp, s_axi_bvalid,
    output s_axi_bready,
    output s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arvalid,
    input  s_axi_arready,
    input  s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
    output s_axi_rready
  );
endinterface

// File: rtl/axi4_slave_ram.sv
// AXI4 responder backed by a word-addressed RAM. Supports FIXED and INCR bursts
// of up to 256 beats. The write and read engines run independently.
// Ports:
//   aclk    - clock; all logic is on the rising edge
//   aresetn - asynchronous active-low reset
//   bus     - axi4_slave_ram_if.slave carrying the AW/W/B/AR/R channels
// Error responses:
//   SLVERR  - WRAP or reserved burst type, a bad size, or a wrong write beat count
//   DECERR  - a beat whose word index falls beyond MEM_DEPTH
module axi4_slave_ram #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_DEPTH  = 1024
) (
  input logic aclk,
  input logic aresetn,
  axi4_slave_ram_if.slave bus
);
  localparam int BPB = DATA_WIDTH / 8;
  localparam int LSB = $clog2(BPB);
  localparam int IW  = $clog2(MEM_DEPTH);
  localparam logic [2:0] SIZE_OK = 3'(LSB);
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rstate_t;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return (a >> LSB) < ADDR_WIDTH'(MEM_DEPTH);
  endfunction

  function automatic logic [IW-1:0] widx(input logic [ADDR_WIDTH-1:0] a);
    return a[LSB +: IW];
  endfunction

  // ---------------- write engine ----------------
  wstate_t w_state, w_next;
  logic [ID_WIDTH-1:0]   w_id;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [7:0]            w_len;
  logic                  w_fixed, w_slv, w_dec;
  logic [8:0]            w_cnt;   // saturates at 256 so overlong bursts still flag
  logic [1:0]            w_resp;
  logic awready, wready, bvalid, aw_hs, w_hs, w_beat_ok, w_we;

  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) w_state <= W_IDLE;
    else          w_state <= w_next;

  always_comb begin
    w_next  = w_state;
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    case (w_state)
      W_IDLE: begin awready = 1'b1; if (bus.s_axi_awvalid) w_next = W_DATA; end
      W_DATA: begin wready = 1'b1; if (bus.s_axi_wvalid && bus.s_axi_wlast) w_next = W_RESP; end
      W_RESP: begin bvalid = 1'b1; if (bus.s_axi_bready) w_next = W_IDLE; end
      default: w_next = W_IDLE;
    endcase
  end

  assign aw_hs     = awready & bus.s_axi_awvalid;
  assign w_hs      = wready & bus.s_axi_wvalid;
  // Beats beyond awlen+1 are accepted but never reach the RAM.
  assign w_beat_ok = w_cnt <= {1'b0, w_len};
  assign w_we      = w_hs & w_beat_ok & ~w_slv & in_range(w_addr);

  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      w_id <= '0; w_addr <= '0; w_len <= '0; w_fixed <= 1'b0;
      w_slv <= 1'b0; w_dec <= 1'b0; w_cnt <= '0; w_resp <= OKAY;
    end else if (aw_hs) begin
      w_id    <= bus.s_axi_awid;
      w_addr  <= bus.s_axi_awaddr;
      w_len   <= bus.s_axi_awlen;
      w_fixed <= bus.s_axi_awburst == 2'b00;
      w_slv   <= bus.s_axi_awburst[1] | (bus.s_axi_awsize != SIZE_OK);
      w_dec   <= 1'b0;
      w_cnt   <= '0;
    end else if (w_hs) begin
      if (!w_fixed) w_addr <= w_addr + ADDR_WIDTH'(BPB);
      if (!w_cnt[8]) w_cnt <= w_cnt + 9'd1;
      if (w_beat_ok && !in_range(w_addr)) w_dec <= 1'b1;
      // Resolve the response on the closing beat; the current beat's decode
      // error is folded in directly since w_dec only updates after this edge.
      if (bus.s_axi_wlast)
        w_resp <= (w_slv || w_cnt != {1'b0, w_len})          ? SLVERR :
                  (w_dec || (w_beat_ok && !in_range(w_addr))) ? DECERR : OKAY;
    end

  always_ff @(posedge aclk)
    if (w_we)
      for (int b = 0; b < BPB; b++)
        if (bus.s_axi_wstrb[b]) mem[widx(w_addr)][8*b +: 8] <= bus.s_axi_wdata[8*b +: 8];

  assign bus.s_axi_awready = awready;
  assign bus.s_axi_wready  = wready;
  assign bus.s_axi_bvalid  = bvalid;
  assign bus.s_axi_bid     = w_id;
  assign bus.s_axi_bresp   = w_resp;

  // ---------------- read engine ----------------
  rstate_t r_state, r_next;
  logic [ID_WIDTH-1:0]   r_id;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len, r_cnt;
  logic                  r_fixed, r_slv, r_last;
  logic [DATA_WIDTH-1:0] r_data;
  logic [1:0]            r_resp;
  logic arready, rvalid, ar_hs, r_hs;

  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) r_state <= R_IDLE;
    else          r_state <= r_next;

  always_comb begin
    r_next  = r_state;
    arready = 1'b0;
    rvalid  = 1'b0;
    case (r_state)
      R_IDLE:  begin arready = 1'b1; if (bus.s_axi_arvalid) r_next = R_FETCH; end
      R_FETCH: r_next = R_DATA;
      R_DATA:  begin rvalid = 1'b1; if (bus.s_axi_rready) r_next = r_last ? R_IDLE : R_FETCH; end
      default: r_next = R_IDLE;
    endcase
  end

  assign ar_hs = arready & bus.s_axi_arvalid;
  assign r_hs  = rvalid & bus.s_axi_rready;

  // The read port samples mem before any same-edge write lands, so a
  // collision returns the old word.
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      r_id <= '0; r_addr <= '0; r_len <= '0; r_cnt <= '0; r_fixed <= 1'b0;
      r_slv <= 1'b0; r_last <= 1'b0; r_data <= '0; r_resp <= OKAY;
    end else if (ar_hs) begin
      r_id    <= bus.s_axi_arid;
      r_addr  <= bus.s_axi_araddr;
      r_len   <= bus.s_axi_arlen;
      r_fixed <= bus.s_axi_arburst == 2'b00;
      r_slv   <= bus.s_axi_arburst[1] | (bus.s_axi_arsize != SIZE_OK);
      r_cnt   <= '0;
    end else if (r_state == R_FETCH) begin
      r_last <= r_cnt == r_len;
      if (r_slv)                 begin r_data <= '0; r_resp <= SLVERR; end
      else if (!in_range(r_addr)) begin r_data <= '0; r_resp <= DECERR; end
      else                       begin r_data <= mem[widx(r_addr)]; r_resp <= OKAY; end
    end else if (r_hs && !r_last) begin
      if (!r_fixed) r_addr <= r_addr + ADDR_WIDTH'(BPB);
      r_cnt <= r_cnt + 8'd1;
    end

  assign bus.s_axi_arready = arready;
  assign bus.s_axi_rvalid  = rvalid;
  assign bus.s_axi_rid     = r_id;
  assign bus.s_axi_rdata   = r_data;
  assign bus.s_axi_rresp   = r_resp;
  assign bus.s_axi_rlast   = r_last;
endmodule

// File: tb/tb_axi4_slave_ram.sv
module tb_axi4_slave_ram;
  localparam int TMO = 200;
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;

  logic aclk, aresetn;
  int checks = 0, errors = 0;

  typedef struct { logic [3:0] id; logic [1:0] resp; } bexp_t;
  typedef struct { logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; } rexp_t;
  bexp_t bq[$];
  rexp_t rq[$];

  logic [31:0] wbuf [16];
  logic [3:0]  sbuf [16];
  logic [31:0] rexp [16];
  logic [31:0] rexp2 [16];

  axi4_slave_ram_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4)) bus ();
  axi4_slave_ram #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .MEM_DEPTH(1024))
    dut (.aclk(aclk), .aresetn(aresetn), .bus(bus));

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input int nbeats, input logic [1:0] exp_resp,
                          input int bhold);
    int t;
    bexp_t e;
    bq.push_back('{id, exp_resp});
    bus.s_axi_awid = id; bus.s_axi_awaddr = addr; bus.s_axi_awlen = len;
    bus.s_axi_awsize = 3'd2; bus.s_axi_awburst = burst; bus.s_axi_awvalid = 1'b1;
    t = 0;
    while (!bus.s_axi_awready && t < TMO) begin @(posedge aclk); #1; t++; end
    @(posedge aclk); #1;
    bus.s_axi_awvalid = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      bus.s_axi_wdata = wbuf[i]; bus.s_axi_wstrb = sbuf[i];
      bus.s_axi_wlast = (i == nbeats - 1); bus.s_axi_wvalid = 1'b1;
      t = 0;
      while (!bus.s_axi_wready && t < TMO) begin @(posedge aclk); #1; t++; end
      if (t >= TMO) begin
        checks++; errors++; $display("FAIL w_timeout beat %0d: wready never rose, required 1", i);
      end
      @(posedge aclk); #1;
    end
    bus.s_axi_wvalid = 1'b0; bus.s_axi_wlast = 1'b0;
    t = 0;
    while (!bus.s_axi_bvalid && t < TMO) begin @(posedge aclk); #1; t++; end
    e = bq.pop_front();
    checks++;
    if (!bus.s_axi_bvalid) begin
      errors++; $display("FAIL b_timeout addr %h: bvalid never rose", addr);
    end else begin
      if ({bus.s_axi_bid, bus.s_axi_bresp} !== {e.id, e.resp}) begin
        errors++;
        $display("FAIL bresp addr %h: got id %h resp %b, required id %h resp %b",
                 addr, bus.s_axi_bid, bus.s_axi_bresp, e.id, e.resp);
      end
      if (bhold > 0) begin
        repeat (bhold) @(posedge aclk);
        #1;
        checks++;
        if ({bus.s_axi_bvalid, bus.s_axi_bresp} !== {1'b1, e.resp}) begin
          errors++;
          $display("FAIL b_hold: got bvalid %b resp %b, required 1 %b",
                   bus.s_axi_bvalid, bus.s_axi_bresp, e.resp);
        end
      end
      bus.s_axi_bready = 1'b1;
      @(posedge aclk); #1;
      bus.s_axi_bready = 1'b0;
    end
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] exp_resp, input int hold_beat);
    int t, n;
    rexp_t e;
    logic [37:0] snap;
    n = int'(len) + 1;
    for (int i = 0; i < n; i++) rq.push_back('{id, rexp[i], exp_resp, i == n - 1});
    bus.s_axi_arid = id; bus.s_axi_araddr = addr; bus.s_axi_arlen = len;
    bus.s_axi_arsize = 3'd2; bus.s_axi_arburst = 2'b01; bus.s_axi_arvalid = 1'b1;
    t = 0;
    while (!bus.s_axi_arready && t < TMO) begin @(posedge aclk); #1; t++; end
    @(posedge aclk); #1;
    bus.s_axi_arvalid = 1'b0;
    for (int i = 0; i < n; i++) begin
      t = 0;
      while (!bus.s_axi_rvalid && t < TMO) begin @(posedge aclk); #1; t++; end
      e = rq.pop_front();
      checks++;
      if (!bus.s_axi_rvalid) begin
        errors++; $display("FAIL r_timeout addr %h beat %0d: rvalid never rose", addr, i);
        return;
      end
      if ({bus.s_axi_rid, bus.s_axi_rdata, bus.s_axi_rresp, bus.s_axi_rlast} !==
          {e.id, e.data, e.resp, e.last}) begin
        errors++;
        $display("FAIL rbeat addr %h beat %0d: got id %h data %h resp %b last %b, required id %h data %h resp %b last %b",
                 addr, i, bus.s_axi_rid, bus.s_axi_rdata, bus.s_axi_rresp, bus.s_axi_rlast,
                 e.id, e.data, e.resp, e.last);
      end
      if (i == hold_beat) begin
        snap = {bus.s_axi_rid, bus.s_axi_rdata, bus.s_axi_rlast, bus.s_axi_rvalid};
        repeat (5) @(posedge aclk);
        #1;
        checks++;
        if ({bus.s_axi_rid, bus.s_axi_rdata, bus.s_axi_rlast, bus.s_axi_rvalid} !== snap) begin
          errors++;
          $display("FAIL r_hold beat %0d: got data %h last %b valid %b, required data %h last %b valid 1",
                   i, bus.s_axi_rdata, bus.s_axi_rlast, bus.s_axi_rvalid, e.data, e.last);
        end
      end
      bus.s_axi_rready = 1'b1;
      @(posedge aclk); #1;
      bus.s_axi_rready = 1'b0;
    end
  endtask

  task automatic test_reset;
    checks++;
    if ({bus.s_axi_awready, bus.s_axi_arready, bus.s_axi_wready, bus.s_axi_bvalid,
         bus.s_axi_rvalid, bus.s_axi_rlast} !== 6'b110000) begin
      errors++; $display("FAIL reset_ctrl: got %b, required 110000",
        {bus.s_axi_awready, bus.s_axi_arready, bus.s_axi_wready, bus.s_axi_bvalid,
         bus.s_axi_rvalid, bus.s_axi_rlast});
    end
    checks++;
    if ({bus.s_axi_bid, bus.s_axi_bresp, bus.s_axi_rid, bus.s_axi_rresp, bus.s_axi_rdata} !== '0) begin
      errors++; $display("FAIL reset_data: got bid %h bresp %b rid %h rresp %b rdata %h, required all 0",
        bus.s_axi_bid, bus.s_axi_bresp, bus.s_axi_rid, bus.s_axi_rresp, bus.s_axi_rdata);
    end
  endtask

  task automatic test_incr;
    for (int i = 0; i < 4; i++) begin wbuf[i] = 32'hA0 + i; sbuf[i] = 4'hF; rexp[i] = 32'hA0 + i; end
    do_write(4'd3, 32'h10, 8'd3, 2'b01, 4, OKAY, 0);
    do_read(4'd5, 32'h10, 8'd3, OKAY, -1);
  endtask

  task automatic test_strobe;
    wbuf[0] = 32'h11223344; sbuf[0] = 4'hF;
    do_write(4'd1, 32'h20, 8'd0, 2'b01, 1, OKAY, 0);
    wbuf[0] = 32'hAABBCCDD; sbuf[0] = 4'h5;
    do_write(4'd2, 32'h20, 8'd0, 2'b01, 1, OKAY, 0);
    rexp[0] = 32'h11BB33DD;
    do_read(4'd2, 32'h20, 8'd0, OKAY, -1);
  endtask

  task automatic test_fixed;
    for (int i = 0; i < 3; i++) begin wbuf[i] = i + 1; sbuf[i] = 4'hF; end
    do_write(4'd7, 32'h40, 8'd2, 2'b00, 3, OKAY, 0);
    rexp[0] = 32'd3;
    do_read(4'd7, 32'h40, 8'd0, OKAY, -1);
    wbuf[0] = 32'hDEAD; sbuf[0] = 4'hF;
    do_write(4'd8, 32'h40, 8'd0, 2'b11, 1, SLVERR, 0);
    do_read(4'd8, 32'h40, 8'd0, OKAY, -1);
  endtask

  task automatic test_errors;
    wbuf[0] = 32'h55; sbuf[0] = 4'hF;
    do_write(4'd9, 32'd4096, 8'd0, 2'b01, 1, DECERR, 0);
    rexp[0] = 32'h0;
    do_read(4'd9, 32'd4096, 8'd0, DECERR, -1);
    wbuf[0] = 32'h1; wbuf[1] = 32'h2; sbuf[0] = 4'hF; sbuf[1] = 4'hF;
    do_write(4'd10, 32'h200, 8'd3, 2'b01, 2, SLVERR, 0);
  endtask

  task automatic test_backpressure;
    for (int i = 0; i < 4; i++) rexp[i] = 32'hA0 + i;
    do_read(4'd4, 32'h10, 8'd3, OKAY, 1);
    wbuf[0] = 32'hC0FFEE; sbuf[0] = 4'hF;
    do_write(4'd6, 32'h80, 8'd0, 2'b01, 1, OKAY, 4);
  endtask

  task automatic test_concurrent;
    for (int i = 0; i < 4; i++) begin
      wbuf[i] = 32'hB0 + i; sbuf[i] = 4'hF; rexp[i] = 32'hA0 + i; rexp2[i] = 32'hB0 + i;
    end
    fork
      do_write(4'd11, 32'h100, 8'd3, 2'b01, 4, OKAY, 0);
      do_read(4'd12, 32'h10, 8'd3, OKAY, -1);
    join
    for (int i = 0; i < 4; i++) rexp[i] = rexp2[i];
    do_read(4'd13, 32'h100, 8'd3, OKAY, -1);
  endtask

  task automatic test_reset_mid_burst;
    bus.s_axi_awid = 4'd14; bus.s_axi_awaddr = 32'h300; bus.s_axi_awlen = 8'd3;
    bus.s_axi_awsize = 3'd2; bus.s_axi_awburst = 2'b01; bus.s_axi_awvalid = 1'b1;
    @(posedge aclk); #1;
    bus.s_axi_awvalid = 1'b0;
    bus.s_axi_wstrb = 4'hF; bus.s_axi_wvalid = 1'b1;
    for (int i = 0; i < 2; i++) begin bus.s_axi_wdata = 32'hE0 + i; @(posedge aclk); #1; end
    bus.s_axi_wdata = 32'hE2;
    #2 aresetn = 1'b0;
    #1 test_reset();
    bus.s_axi_wvalid = 1'b0;
    @(negedge aclk); aresetn = 1'b1;
    @(posedge aclk); #1;
    for (int i = 0; i < 4; i++) begin wbuf[i] = 32'hF0 + i; sbuf[i] = 4'hF; rexp[i] = 32'hF0 + i; end
    do_write(4'd15, 32'h300, 8'd3, 2'b01, 4, OKAY, 0);
    do_read(4'd15, 32'h300, 8'd3, OKAY, -1);
  endtask

  initial begin
    aresetn = 1'b0;
    bus.s_axi_awid = '0; bus.s_axi_awaddr = '0; bus.s_axi_awlen = '0; bus.s_axi_awsize = '0;
    bus.s_axi_awburst = '0; bus.s_axi_awvalid = 1'b0;
    bus.s_axi_wdata = '0; bus.s_axi_wstrb = '0; bus.s_axi_wlast = 1'b0; bus.s_axi_wvalid = 1'b0;
    bus.s_axi_bready = 1'b0;
    bus.s_axi_arid = '0; bus.s_axi_araddr = '0; bus.s_axi_arlen = '0; bus.s_axi_arsize = '0;
    bus.s_axi_arburst = '0; bus.s_axi_arvalid = 1'b0; bus.s_axi_rready = 1'b0;
    repeat (3) @(posedge aclk);
    #1 test_reset();
    @(negedge aclk); aresetn = 1'b1;
    @(posedge aclk); #1;
    test_incr();
    test_strobe();
    test_fixed();
    test_errors();
    test_backpressure();
    test_concurrent();
    test_reset_mid_burst();
    repeat (2) @(posedge aclk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
